// File: rtl/backlight_pkg.sv
// Shared types and widths for the backlight fader and its PWM-facing neighbours.
package backlight_pkg;

  localparam int DUTY_W = 5;
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'((2 ** DUTY_W) - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RAMP,
    S_DIM_RAMP,
    S_DIMMED
  } fader_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks, for slow-rate UI timing.
module tick_prescaler #(
  parameter int DIV = 256
) (
  input  logic CLK,
  input  logic nRST,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/backlight_fader.sv
// Brightness fader feeding the backlight PWM: accepts targets, ramps one LSB per tick,
// and dims itself after a period without user activity.
module backlight_fader
  import backlight_pkg::*;
#(
  parameter int STEP_DIV     = 256,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int DIM_LEVEL    = 4,
  parameter int RESET_LEVEL  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DUTY_W-1:0] Target_Val,
  input  logic              Target_Valid,
  output logic              Target_Ready,
  input  logic              Activity,
  input  logic              Enable,
  output logic [DUTY_W-1:0] Duty_Val,
  output logic              Ramp_Busy,
  output logic              Dimmed
);

  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMEOUT_SAT  = TW'(IDLE_TIMEOUT);
  localparam logic [DUTY_W-1:0] DIM_DUTY   = DUTY_W'(DIM_LEVEL);
  localparam logic [DUTY_W-1:0] RESET_DUTY = DUTY_W'(RESET_LEVEL);
  localparam fader_state_t RESET_STATE = (RESET_LEVEL != 0) ? S_RAMP : S_HOLD;

  fader_state_t      state;
  logic [DUTY_W-1:0] duty;
  logic [DUTY_W-1:0] target_reg;
  logic [TW-1:0]     idle_cnt;
  logic              enable_q;
  logic              tick;
  logic              accept;
  logic [DUTY_W-1:0] goal;
  logic [DUTY_W-1:0] step_val;

  tick_prescaler #(.DIV(STEP_DIV)) u_prescaler (
    .CLK  (CLK),
    .nRST (nRST),
    .tick (tick)
  );

  assign Target_Ready = (state == S_HOLD) || (state == S_DIMMED);
  assign Ramp_Busy    = (state == S_RAMP) || (state == S_DIM_RAMP);
  assign Dimmed       = (state == S_DIM_RAMP) || (state == S_DIMMED);
  assign Duty_Val     = duty;
  assign accept       = Target_Valid && Target_Ready;

  // While dimming the ramp never climbs: a target below the dim level is kept as is.
  always_comb begin
    goal = target_reg;
    if ((state == S_DIM_RAMP) && (target_reg > DIM_DUTY)) begin
      goal = DIM_DUTY;
    end
    step_val = duty;
    if ((duty < goal) && (duty != DUTY_MAX)) begin
      step_val = duty + DUTY_W'(1);
    end else if ((duty > goal) && (duty != '0)) begin
      step_val = duty - DUTY_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RESET_STATE;
      duty       <= '0;
      target_reg <= RESET_DUTY;
      idle_cnt   <= '0;
      enable_q   <= 1'b1;
    end else begin
      enable_q <= Enable;
      if (accept) begin
        target_reg <= Target_Val;
      end
      if (!Enable) begin
        state    <= S_HOLD;
        duty     <= '0;
        idle_cnt <= '0;
      end else if (!enable_q) begin
        // First enabled cycle: duty is 0, so fade in to whatever target is now current.
        idle_cnt <= '0;
        state    <= ((accept ? Target_Val : target_reg) != '0) ? S_RAMP : S_HOLD;
      end else begin
        case (state)
          S_HOLD: begin
            if (accept) begin
              idle_cnt <= '0;
              if (Target_Val != duty) begin
                state <= S_RAMP;
              end
            end else if (Activity) begin
              idle_cnt <= '0;
            end else if (tick && (idle_cnt != TIMEOUT_SAT)) begin
              if ((idle_cnt == TIMEOUT_LAST) && (duty > DIM_DUTY)) begin
                state    <= S_DIM_RAMP;
                idle_cnt <= '0;
              end else begin
                idle_cnt <= idle_cnt + TW'(1);
              end
            end
          end
          S_RAMP: begin
            if (duty == goal) begin
              state    <= S_HOLD;
              idle_cnt <= '0;
            end else if (tick) begin
              duty <= step_val;
              if (step_val == goal) begin
                state    <= S_HOLD;
                idle_cnt <= '0;
              end
            end
          end
          S_DIM_RAMP: begin
            if (Activity) begin
              state <= S_RAMP;
            end else if (duty == goal) begin
              state <= S_DIMMED;
            end else if (tick) begin
              duty <= step_val;
              if (step_val == goal) begin
                state <= S_DIMMED;
              end
            end
          end
          S_DIMMED: begin
            if (accept || Activity) begin
              state <= S_RAMP;
            end
          end
          default: state <= S_HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_backlight_fader.sv
// Directed plus randomized bench for backlight_fader; expected duty follows a
// "one LSB per tick toward the target" model driven by a free-running tick count.
module tb_backlight_fader;

  localparam int STEP_DIV     = 4;
  localparam int IDLE_TIMEOUT = 8;
  localparam int DIM_LEVEL    = 4;
  localparam int RESET_LEVEL  = 16;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [4:0] Target_Val = '0;
  logic       Target_Valid = 1'b0;
  logic       Activity = 1'b0;
  logic       Enable = 1'b1;
  logic       Target_Ready;
  logic [4:0] Duty_Val;
  logic       Ramp_Busy;
  logic       Dimmed;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int md_cur = 0;

  backlight_fader #(
    .STEP_DIV     (STEP_DIV),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .DIM_LEVEL    (DIM_LEVEL),
    .RESET_LEVEL  (RESET_LEVEL)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .Target_Val   (Target_Val),
    .Target_Valid (Target_Valid),
    .Target_Ready (Target_Ready),
    .Activity     (Activity),
    .Enable       (Enable),
    .Duty_Val     (Duty_Val),
    .Ramp_Busy    (Ramp_Busy),
    .Dimmed       (Dimmed)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; every STEP_DIV-th edge is a prescaler tick.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic bit is_tick();
    return (cyc != 0) && ((cyc % STEP_DIV) == 0);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      next_edge();
      if (is_tick()) seen++;
    end
  endtask

  task automatic send_target(input logic [4:0] v, input logic act);
    int waited;
    waited = 0;
    Target_Val   = v;
    Target_Valid = 1'b1;
    Activity     = act;
    while ((Target_Ready !== 1'b1) && (waited < 200)) begin
      next_edge();
      waited++;
    end
    check_output("accept_ready", {31'b0, Target_Ready}, 32'd1);
    next_edge();
    Target_Valid = 1'b0;
    Activity     = 1'b0;
  endtask

  // Duty moves one step toward goal on each tick; flags follow "still moving or not".
  task automatic ramp_check(input string tag, input int start, input int goal, input int stop_at,
                            input logic exp_dim);
    int md;
    int guard;
    md = start;
    guard = 0;
    while ((md != stop_at) && (guard < 40 * STEP_DIV)) begin
      next_edge();
      guard++;
      if (is_tick()) md += (goal > md) ? 1 : -1;
      check_output({tag, "_duty"}, {27'b0, Duty_Val}, md);
    end
    check_output({tag, "_busy"}, {31'b0, Ramp_Busy}, (md != goal) ? 32'd1 : 32'd0);
    check_output({tag, "_ready"}, {31'b0, Target_Ready}, (md == goal) ? 32'd1 : 32'd0);
    check_output({tag, "_dimmed"}, {31'b0, Dimmed}, {31'b0, exp_dim});
    md_cur = md;
  endtask

  task automatic apply_stimulus();
    int v;
    int gap;
    logic a;

    // Reset held across a few edges
    repeat (3) @(posedge CLK);
    #1;
    check_output("rst_duty", {27'b0, Duty_Val}, 32'd0);
    check_output("rst_ready", {31'b0, Target_Ready}, 32'd0);
    check_output("rst_busy", {31'b0, Ramp_Busy}, 32'd1);
    check_output("rst_dimmed", {31'b0, Dimmed}, 32'd0);
    nRST = 1'b1;
    $display("[TB] power-up fade");
    ramp_check("powerup", 0, RESET_LEVEL, RESET_LEVEL, 1'b0);

    $display("[TB] handshake");
    send_target(5'd31, 1'b0);
    check_output("hs_ready_low", {31'b0, Target_Ready}, 32'd0);
    check_output("hs_busy", {31'b0, Ramp_Busy}, 32'd1);
    Target_Val   = 5'd8;
    Target_Valid = 1'b1;
    ramp_check("hs_up", 16, 31, 31, 1'b0);
    next_edge();
    Target_Valid = 1'b0;
    check_output("hs_held_accept", {31'b0, Ramp_Busy}, 32'd1);
    ramp_check("hs_down", 31, 8, 8, 1'b0);

    $display("[TB] randomized targets");
    for (int i = 0; i < 10; i++) begin
      v   = int'($urandom_range(0, 31));
      a   = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) next_edge();
      send_target(5'(v), a);
      if (v != md_cur) begin
        ramp_check("rand", md_cur, v, v, 1'b0);
      end else begin
        check_output("rand_same_busy", {31'b0, Ramp_Busy}, 32'd0);
        check_output("rand_same_duty", {27'b0, Duty_Val}, md_cur);
      end
    end
    send_target(5'd16, 1'b0);
    if (md_cur != 16) ramp_check("to16", md_cur, 16, 16, 1'b0);

    $display("[TB] auto-dim");
    wait_ticks(IDLE_TIMEOUT - 1);
    check_output("dim_early", {31'b0, Dimmed}, 32'd0);
    wait_ticks(1);
    check_output("dim_enter", {31'b0, Dimmed}, 32'd1);
    check_output("dim_ready", {31'b0, Target_Ready}, 32'd0);
    ramp_check("dim", 16, DIM_LEVEL, DIM_LEVEL, 1'b1);
    Activity = 1'b1;
    next_edge();
    Activity = 1'b0;
    check_output("wake_dimmed", {31'b0, Dimmed}, 32'd0);
    check_output("wake_busy", {31'b0, Ramp_Busy}, 32'd1);
    ramp_check("wake", DIM_LEVEL, 16, 16, 1'b0);

    $display("[TB] activity at timeout");
    wait_ticks(IDLE_TIMEOUT - 1);
    repeat (STEP_DIV - 1) next_edge();
    Activity = 1'b1;
    next_edge();
    Activity = 1'b0;
    check_output("sim_dimmed", {31'b0, Dimmed}, 32'd0);
    check_output("sim_busy", {31'b0, Ramp_Busy}, 32'd0);
    wait_ticks(IDLE_TIMEOUT - 1);
    check_output("sim_restart_early", {31'b0, Dimmed}, 32'd0);
    wait_ticks(1);
    check_output("sim_restart_dim", {31'b0, Dimmed}, 32'd1);
    ramp_check("dim2", 16, DIM_LEVEL, DIM_LEVEL, 1'b1);

    $display("[TB] boundaries");
    send_target(5'd0, 1'b1);
    check_output("dimmed_accept", {31'b0, Dimmed}, 32'd0);
    ramp_check("to0", DIM_LEVEL, 0, 0, 1'b0);
    wait_ticks(IDLE_TIMEOUT + 2);
    check_output("floor_duty", {27'b0, Duty_Val}, 32'd0);
    check_output("floor_dimmed", {31'b0, Dimmed}, 32'd0);
    send_target(5'd31, 1'b0);
    ramp_check("to31", 0, 31, 31, 1'b0);
    wait_ticks(2);
    check_output("ceil_duty", {27'b0, Duty_Val}, 32'd31);
    wait_ticks(3);
    send_target(5'd31, 1'b0);
    check_output("same_busy", {31'b0, Ramp_Busy}, 32'd0);
    check_output("same_ready", {31'b0, Target_Ready}, 32'd1);
    wait_ticks(IDLE_TIMEOUT - 1);
    check_output("same_timer_cleared", {31'b0, Dimmed}, 32'd0);
    wait_ticks(1);
    check_output("same_dim", {31'b0, Dimmed}, 32'd1);
    ramp_check("dim3", 31, DIM_LEVEL, DIM_LEVEL, 1'b1);
    send_target(5'd3, 1'b0);
    ramp_check("to3", DIM_LEVEL, 3, 3, 1'b0);
    wait_ticks(IDLE_TIMEOUT + 4);
    check_output("low_no_dim", {31'b0, Dimmed}, 32'd0);
    check_output("low_duty", {27'b0, Duty_Val}, 32'd3);
    check_output("low_ready", {31'b0, Target_Ready}, 32'd1);

    $display("[TB] enable");
    send_target(5'd20, 1'b0);
    ramp_check("to10", 3, 20, 10, 1'b0);
    Enable = 1'b0;
    next_edge();
    check_output("dis_duty", {27'b0, Duty_Val}, 32'd0);
    check_output("dis_busy", {31'b0, Ramp_Busy}, 32'd0);
    check_output("dis_ready", {31'b0, Target_Ready}, 32'd1);
    repeat (5) next_edge();
    check_output("dis_hold", {27'b0, Duty_Val}, 32'd0);
    Enable = 1'b1;
    next_edge();
    check_output("reen_busy", {31'b0, Ramp_Busy}, 32'd1);
    ramp_check("reen", 0, 20, 20, 1'b0);

    $display("[TB] reset mid-dim");
    wait_ticks(IDLE_TIMEOUT);
    check_output("pre_rst_dim", {31'b0, Dimmed}, 32'd1);
    wait_ticks(2);
    check_output("pre_rst_duty", {27'b0, Duty_Val}, 32'd18);
    #3;
    nRST = 1'b0;
    #1;
    check_output("arst_duty", {27'b0, Duty_Val}, 32'd0);
    check_output("arst_busy", {31'b0, Ramp_Busy}, 32'd1);
    check_output("arst_ready", {31'b0, Target_Ready}, 32'd0);
    check_output("arst_dimmed", {31'b0, Dimmed}, 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
